// File: rtl/pc_trap_dump_unit.sv
// pc_trap_dump_unit
// Watches the MIPS core PC. When it reaches a trap address the core is
// frozen and a fixed window of data-memory words is streamed out over a
// valid/ready port. Also counts PC transitions for run statistics.
// Optional feature macro: DUMP_ALT_PC_EN (adds a second trap address ALT_PC).
module pc_trap_dump_unit #(
    parameter logic [31:0] END_PC    = 32'h30,
    parameter logic [31:0] ALT_PC    = 32'h20,
    parameter int          BASE_WORD = 12,
    parameter int          NUM_WORDS = 96,
    parameter int          MEM_AW    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic              pc_valid,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic [15:0]       dump_index,
    output logic              dump_last,
    output logic              core_halt,
    output logic              done,
    output logic [31:0]       pc_change_cnt
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Both trap addresses are compared against a word-aligned PC, and an
    // empty dump window makes no sense; reject such builds at elaboration.
    if (NUM_WORDS < 1 || END_PC[1:0] != 2'b00 || ALT_PC[1:0] != 2'b00) begin : g_param_check
        $error("pc_trap_dump_unit: NUM_WORDS must be >= 1 and trap PCs word aligned");
    end

    logic [2:0]  state;
    logic [15:0] counter;
    logic [31:0] prev_pc;
    logic        prev_valid;
    logic        trap_hit;
    logic        is_last;

    // Trap comparator; the alternate address only exists when the feature is built in.
`ifdef DUMP_ALT_PC_EN
    assign trap_hit = pc_valid && ((pc == END_PC) || (pc == ALT_PC));
`else
    assign trap_hit = pc_valid && (pc == END_PC);
`endif

    assign is_last = (counter == 16'(NUM_WORDS - 1));

    // Outputs that are pure functions of the FSM state.
    always_comb begin
        mem_rd_en   = (state == ISSUE);
        mem_rd_addr = '0;
        if (state == ISSUE) begin
            mem_rd_addr = MEM_AW'(BASE_WORD) + MEM_AW'(counter);
        end
        dump_valid  = (state == SEND);
        core_halt   = (state != IDLE);
        done        = (state == DONE);
    end

    // Dump sequencer: issue a read, capture the returned word, then hold it until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            dump_data  <= '0;
            dump_index <= '0;
            dump_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_hit) begin
                        state   <= ISSUE;
                        counter <= '0;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    dump_data  <= mem_rd_data;
                    dump_index <= counter;
                    dump_last  <= is_last;
                    state      <= SEND;
                end
                SEND: begin
                    if (dump_ready) begin
                        if (dump_last) begin
                            state <= DONE;
                        end else begin
                            counter <= counter + 16'd1;
                            state   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // PC transition counter; frozen once the core is halted so the stats stop at the trap.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_change_cnt <= '0;
            prev_pc       <= '0;
            prev_valid    <= 1'b0;
        end else if (!core_halt && pc_valid) begin
            if (!prev_valid || (pc != prev_pc)) begin
                pc_change_cnt <= pc_change_cnt + 32'd1;
            end
            prev_pc    <= pc;
            prev_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_trap_dump_unit.sv
// Testbench for pc_trap_dump_unit.
// Expected dump words are queued as stimulus is issued; independent monitors
// pop and compare whenever the DUT hands over a word or issues a read.
// Honours DUMP_ALT_PC_EN the same way the design does.
module tb_pc_trap_dump_unit;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] index;
        logic        last;
    } exp_t;

`ifdef DUMP_ALT_PC_EN
    localparam int SEQ_CNT = 9;
`else
    localparam int SEQ_CNT = 13;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [15:0] dump_index;
    logic        dump_last;
    logic        core_halt;
    logic        done;
    logic [31:0] pc_change_cnt;

    logic        wrap_en;
    logic        w_pc_valid;
    logic        w_mem_rd_en;
    logic [9:0]  w_mem_rd_addr;
    logic [31:0] w_mem_rd_data;
    logic        w_dump_valid;
    logic        w_dump_ready;
    logic [31:0] w_dump_data;
    logic [15:0] w_dump_index;
    logic        w_dump_last;
    logic        w_core_halt;
    logic        w_done;
    logic [31:0] w_pc_change_cnt;

    logic [31:0] mem [0:1023];
    exp_t        exp_q[$];
    logic [31:0] w_exp[$];

    int          n_checks;
    int          n_pass;
    int          ready_mode;
    int          ready_cyc;

    pc_trap_dump_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_data     (dump_data),
        .dump_index    (dump_index),
        .dump_last     (dump_last),
        .core_halt     (core_halt),
        .done          (done),
        .pc_change_cnt (pc_change_cnt)
    );

    assign w_pc_valid = pc_valid & wrap_en;

    pc_trap_dump_unit #(
        .BASE_WORD (1020),
        .NUM_WORDS (8),
        .MEM_AW    (10)
    ) dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .pc_valid      (w_pc_valid),
        .mem_rd_en     (w_mem_rd_en),
        .mem_rd_addr   (w_mem_rd_addr),
        .mem_rd_data   (w_mem_rd_data),
        .dump_valid    (w_dump_valid),
        .dump_ready    (w_dump_ready),
        .dump_data     (w_dump_data),
        .dump_index    (w_dump_index),
        .dump_last     (w_dump_last),
        .core_halt     (w_core_halt),
        .done          (w_done),
        .pc_change_cnt (w_pc_change_cnt)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data-memory second read port: one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic failNow(input string name, input logic [31:0] actual);
        n_checks++;
        $display("[TB] FAIL %s: got %h, nothing was expected", name, actual);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a PC value for the given number of rising edges.
    task automatic applyStimulus(input logic [31:0] pc_value, input int cycles);
        tick();
        pc       = pc_value;
        pc_valid = 1'b1;
        repeat (cycles - 1) tick();
    endtask

    task automatic pushDump();
        exp_t e;
        for (int k = 0; k < 96; k++) begin
            e.data  = 32'h100 + 32'(k);
            e.index = 16'(k);
            e.last  = (k == 95);
            exp_q.push_back(e);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_rd_en"},   {31'd0, mem_rd_en},   32'd0);
        checkOutput({tag, "_mem_rd_addr"}, {22'd0, mem_rd_addr}, 32'd0);
        checkOutput({tag, "_dump_valid"},  {31'd0, dump_valid},  32'd0);
        checkOutput({tag, "_dump_data"},   dump_data,            32'd0);
        checkOutput({tag, "_dump_index"},  {16'd0, dump_index},  32'd0);
        checkOutput({tag, "_dump_last"},   {31'd0, dump_last},   32'd0);
        checkOutput({tag, "_core_halt"},   {31'd0, core_halt},   32'd0);
        checkOutput({tag, "_done"},        {31'd0, done},        32'd0);
        checkOutput({tag, "_pc_cnt"},      pc_change_cnt,        32'd0);
    endtask

    task automatic applyReset(input int mode);
        tick();
        reset    = 1'b1;
        pc_valid = 1'b0;
        pc       = 32'd0;
        exp_q.delete();
        @(negedge clk);
        ready_mode = mode;
        tick();
        @(negedge clk);
        checkAllZero("reset");
        tick();
        reset = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_done_reached"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic waitIndex(input logic [15:0] idx, input int budget);
        int  k = 0;
        logic found = 1'b0;
        while (!found && k < budget) begin
            @(negedge clk);
            found = dump_valid && (dump_index == idx);
            k++;
        end
        checkOutput("wait_for_index", {31'd0, found}, 32'd1);
    endtask

    // Ready generator: tied high, one cycle in three, or held low.
    initial begin
        ready_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            ready_cyc++;
            case (ready_mode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = (ready_cyc % 3 == 0);
                default: dump_ready = 1'b0;
            endcase
        end
    end

    // Dump monitor: compares accepted words against the scoreboard and checks hold stability.
    initial begin
        exp_t        e;
        logic        held_valid   = 1'b0;
        logic        last_pending = 1'b0;
        logic [31:0] held_data    = '0;
        logic [15:0] held_index   = '0;
        logic        held_last    = 1'b0;
        forever begin
            @(negedge clk);
            if (last_pending) begin
                checkOutput("done_after_last", {31'd0, done}, 32'd1);
                last_pending = 1'b0;
            end
            if (held_valid && dump_valid) begin
                checkOutput("hold_data",  dump_data,           held_data);
                checkOutput("hold_index", {16'd0, dump_index}, {16'd0, held_index});
                checkOutput("hold_last",  {31'd0, dump_last},  {31'd0, held_last});
                checkOutput("halt_while_held", {31'd0, core_halt}, 32'd1);
            end
            held_valid = 1'b0;
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    failNow("unexpected_word", dump_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("dump_data",  dump_data,           e.data);
                    checkOutput("dump_index", {16'd0, dump_index}, {16'd0, e.index});
                    checkOutput("dump_last",  {31'd0, dump_last},  {31'd0, e.last});
                    if (e.last) begin
                        checkOutput("done_low_at_last", {31'd0, done}, 32'd0);
                        last_pending = 1'b1;
                    end
                end
            end else if (dump_valid) begin
                held_valid = 1'b1;
                held_data  = dump_data;
                held_index = dump_index;
                held_last  = dump_last;
            end
        end
    end

    // Read-address monitor for the wrap-around instance.
    initial begin
        forever begin
            @(negedge clk);
            if (w_mem_rd_en) begin
                if (w_exp.size() == 0) failNow("wrap_extra_read", {22'd0, w_mem_rd_addr});
                else checkOutput("wrap_rd_addr", {22'd0, w_mem_rd_addr}, w_exp.pop_front());
            end
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        n_checks      = 0;
        n_pass        = 0;
        ready_mode    = 0;
        reset         = 1'b1;
        pc            = 32'd0;
        pc_valid      = 1'b0;
        dump_ready    = 1'b0;
        mem_rd_data   = 32'd0;
        wrap_en       = 1'b1;
        w_dump_ready  = 1'b1;
        w_mem_rd_data = 32'd0;
        for (int a = 0; a < 1024; a++) mem[a] = 32'h100 + 32'(a) - 32'd12;
        w_exp.push_back(32'd1020);
        w_exp.push_back(32'd1021);
        w_exp.push_back(32'd1022);
        w_exp.push_back(32'd1023);
        for (int a = 0; a < 4; a++) w_exp.push_back(32'(a));

        applyReset(0);

        $display("[TB] run 1: PC walk to trap, ready tied high");
        pushDump();
        for (int i = 0; i < 13; i++) applyStimulus(32'(i * 4), 1);
        waitDone("run1", 2000);
        checkOutput("run1_pc_cnt", pc_change_cnt, 32'(SEQ_CNT));
        checkOutput("run1_halt", {31'd0, core_halt}, 32'd1);
        checkOutput("wrap_done", {31'd0, w_done}, 32'd1);
        checkOutput("wrap_reads_all", 32'(w_exp.size()), 32'd0);
        wrap_en = 1'b0;

        $display("[TB] trap PC revisited while done");
        applyStimulus(32'h2C, 2);
        applyStimulus(32'h30, 3);
        @(negedge clk);
        checkOutput("done_sticky", {31'd0, done}, 32'd1);
        checkOutput("done_no_valid", {31'd0, dump_valid}, 32'd0);
        checkOutput("done_no_read", {31'd0, mem_rd_en}, 32'd0);
        checkOutput("done_cnt_frozen", pc_change_cnt, 32'(SEQ_CNT));

        $display("[TB] run 2: ready one cycle in three");
        applyReset(1);
        pushDump();
        for (int i = 0; i < 13; i++) applyStimulus(32'(i * 4), 1);
        waitDone("run2", 4000);
        checkOutput("run2_pc_cnt", pc_change_cnt, 32'(SEQ_CNT));

        $display("[TB] run 3: reset during word 40");
        applyReset(0);
        pushDump();
        applyStimulus(32'h30, 1);
        waitIndex(16'd39, 500);
        ready_mode = 2;
        waitIndex(16'd40, 20);
        tick();
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        ready_mode = 0;
        tick();
        @(negedge clk);
        checkAllZero("midreset");
        pushDump();
        tick();
        reset = 1'b0;
        waitDone("run3", 2000);
        checkOutput("run3_pc_cnt", pc_change_cnt, 32'd1);

        $display("[TB] run 4: alternate trap address");
        applyReset(0);
`ifdef DUMP_ALT_PC_EN
        pushDump();
`endif
        applyStimulus(32'h1C, 5);
        applyStimulus(32'h20, 1);
        tick();
        @(negedge clk);
        checkOutput("alt_pc_cnt", pc_change_cnt, 32'd2);
`ifdef DUMP_ALT_PC_EN
        checkOutput("alt_halt", {31'd0, core_halt}, 32'd1);
        waitDone("run4", 2000);
`else
        checkOutput("alt_no_halt", {31'd0, core_halt}, 32'd0);
        repeat (4) tick();
        @(negedge clk);
        checkOutput("alt_no_halt_later", {31'd0, core_halt}, 32'd0);
        checkOutput("alt_no_read", {31'd0, mem_rd_en}, 32'd0);
        checkOutput("alt_not_done", {31'd0, done}, 32'd0);
        checkOutput("alt_pc_cnt_later", pc_change_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_trap_dump_unit.md
Name: pc_trap_dump_unit

Overview:
- Sits directly downstream of the single-cycle MIPS core.
- Watches the core's PC. When the PC reaches a trap address, it halts the core and streams a fixed window of data-memory words out a valid/ready port.
- Replaces the software dump-and-stop loop with synthesizable hardware. It also counts PC transitions for cycle/instruction statistics.

Parameters:
- END_PC, 32'h30, primary trap PC (byte address).
- ALT_PC, 32'h20, secondary trap PC; only used when DUMP_ALT_PC_EN is defined.
- BASE_WORD, 12, first data-memory word index to dump.
- NUM_WORDS, 96, number of words to dump (must be ≥1).
- MEM_AW, 10, data-memory word-address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  current PC from core.
- pc_valid  in  1  pc is meaningful this cycle (low while the core is in reset).
- mem_rd_en  out  1  read strobe to data-memory second read port.
- mem_rd_addr  out  MEM_AW  word address of the read.
- mem_rd_data  in  32  read data; valid exactly 1 cycle after mem_rd_en.
- dump_valid  out  1  dump_data holds a word.
- dump_ready  in  1  consumer accepts the word.
- dump_data  out  32  dumped memory word.
- dump_index  out  16  index 0..NUM_WORDS-1 of the current word.
- dump_last  out  1  high with dump_valid on index NUM_WORDS-1.
- core_halt  out  1  freeze the core's PC register.
- done  out  1  dump complete; sticky until reset.
- pc_change_cnt  out  32  number of PC transitions observed.

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high: sampled on the rising edge of clk. Reset takes priority over every other event, including mid-dump; an aborted dump is not resumed.
- Reset values: every output is 0, FSM in IDLE, prev_pc = 0, prev_valid = 0.
- FSM states: IDLE, ISSUE, WAIT, SEND, DONE.
- IDLE:
  - Trap when pc_valid=1 and pc==END_PC (or pc==ALT_PC with the feature).
  - On trap: next cycle go to ISSUE with core_halt=1 and word counter = 0.
  - A trap is detected on the same cycle as pc_valid rises.
- ISSUE:
  - mem_rd_en=1 and mem_rd_addr = BASE_WORD + counter, truncated to MEM_AW (wrap-around permitted).
  - Next state WAIT.
- WAIT:
  - Latch mem_rd_data into dump_data; dump_index = counter; dump_last = (counter==NUM_WORDS-1).
  - Next state SEND.
- SEND:
  - dump_valid=1. dump_data, dump_index and dump_last stay stable until dump_ready=1.
  - On the handshake cycle: if last word, go to DONE; otherwise counter+1 and go to ISSUE.
  - dump_valid drops the cycle after the handshake.
  - Throughput: one word per 3 cycles with ready held high.
- DONE:
  - done=1, core_halt=1, dump_valid=0.
  - Stays in DONE until reset; further PC matches are ignored.
- core_halt: high from the cycle after trap detection through DONE.
- Trap matches in any state other than IDLE are ignored.
- pc_change_cnt:
  - Increments by 1 on a cycle where pc_valid=1 and (prev_valid=0 or pc != prev_pc).
  - Then prev_pc ← pc and prev_valid ← 1.
  - Wraps modulo 2^32. Frozen while core_halt=1.
  - The trap-cycle PC change is counted.
- mem_rd_en is 0 in every state except ISSUE.

Optional Feature:
- Macro DUMP_ALT_PC_EN.
- Defined: trap comparator also matches ALT_PC, with the same behaviour as END_PC.
- Undefined: only END_PC traps; ALT_PC is unused and no comparator is built.

Test Plan:
- PC sequence 0,4,8,...,0x30 with memory word[12+i]=i+0x100 and ready tied to 1 → 96 words 0x100..0x15F in order, dump_index 0..95, dump_last only on index 95. done rises the cycle after the handshake on word 95. pc_change_cnt=13.
- Same run with dump_ready toggling 1-in-3 → dump_data and dump_index stable while valid and not ready. No words lost or duplicated; core_halt=1 throughout.
- Reset asserted during SEND of word 40 → next cycle all outputs 0 and state IDLE. A subsequent trap restarts the dump at index 0.
- PC held at 0x1C for 5 cycles, then 0x1C→0x20 → without DUMP_ALT_PC_EN: no halt, pc_change_cnt += 1. With the macro: trap fires and core_halt=1 next cycle.
- BASE_WORD=1020, MEM_AW=10, NUM_WORDS=8 → mem_rd_addr sequence 1020..1023, 0..3.
- PC reaches 0x30 again while in DONE → no new dump, done stays 1, pc_change_cnt unchanged.
